// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline hazard and flow-control unit for the 5-stage pipeline.
//
// Owns the PC, IF/ID and ID/EX enables and squash controls. It keeps a shadow
// scoreboard of in-flight destinations (DX, XM, MW slots), stalls decode on RAW
// hazards, and sequences branch flushes, data-memory freezes and HALT drain.
//
// Configuration macro: FORWARDING_EN
//   defined   - a forwarding network exists; only load-use against DX stalls.
//   undefined - any RAW match against DX, XM or MW stalls until the producer
//               has left MW (register file is not write-through).
//
// Ports:
//   clk, rst                   rising-edge clock, async active-high reset
//   id_valid                   IF/ID holds a real instruction
//   readSel1/2, read1Used/2Used source selects of the IF/ID instruction and use flags
//   id_regWrite, id_writeRegSel decoded destination write enable and register
//   id_memRead, id_HALT        decoded load / HALT
//   ex_flush                   EX redirect this cycle
//   mem_stall                  data memory busy, whole pipeline freezes
//   pc_en, ifid_en, ifid_flush PC / IF/ID controls
//   idex_en, idex_bubble       ID/EX enable and control-field squash
//   halted                     HALT has issued; front end frozen
//   stall_cycles               saturating count of hazard-stall cycles
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  readSel1,
    input  logic [2:0]  readSel2,
    input  logic        read1Used,
    input  logic        read2Used,
    input  logic        id_regWrite,
    input  logic [2:0]  id_writeRegSel,
    input  logic        id_memRead,
    input  logic        id_HALT,
    input  logic        ex_flush,
    input  logic        mem_stall,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    // Scoreboard slots: {valid, regWrite, dest, memRead}
    logic        dx_valid_r, dx_rw_r, dx_mr_r;
    logic [2:0]  dx_dest_r;
    logic        xm_valid_r, xm_rw_r, xm_mr_r;
    logic [2:0]  xm_dest_r;
    logic        mw_valid_r, mw_rw_r, mw_mr_r;
    logic [2:0]  mw_dest_r;
    logic        halted_r;
    logic [15:0] stall_cnt_r;

    logic        hazard_s;
    logic        issue_s;
    logic        count_s;
    logic        unused_s;

    // A source depends on a slot when it is read and the slot will write that register.
    function automatic logic src_match(input logic used, input logic [2:0] sel,
                                       input logic v, input logic rw, input logic [2:0] dest);
        return used & v & rw & (dest == sel);
    endfunction

    // memRead is only consulted in DX (and only with forwarding); keep the rest for visibility.
    assign unused_s = ^{dx_mr_r, xm_mr_r, mw_mr_r};

    // RAW hazard detection for the instruction currently in IF/ID.
    always_comb begin
        hazard_s = 1'b0;
`ifdef FORWARDING_EN
        hazard_s = id_valid & dx_mr_r &
                   (src_match(read1Used, readSel1, dx_valid_r, dx_rw_r, dx_dest_r) |
                    src_match(read2Used, readSel2, dx_valid_r, dx_rw_r, dx_dest_r));
`else
        hazard_s = id_valid &
                   (src_match(read1Used, readSel1, dx_valid_r, dx_rw_r, dx_dest_r) |
                    src_match(read2Used, readSel2, dx_valid_r, dx_rw_r, dx_dest_r) |
                    src_match(read1Used, readSel1, xm_valid_r, xm_rw_r, xm_dest_r) |
                    src_match(read2Used, readSel2, xm_valid_r, xm_rw_r, xm_dest_r) |
                    src_match(read1Used, readSel1, mw_valid_r, mw_rw_r, mw_dest_r) |
                    src_match(read2Used, readSel2, mw_valid_r, mw_rw_r, mw_dest_r));
`endif
    end

    // Issue and stall-count qualifiers follow the output priority (freeze > halted > flush > hazard).
    assign issue_s = id_valid & ~halted_r & ~hazard_s & ~ex_flush & ~mem_stall;
    assign count_s = hazard_s & ~halted_r & ~ex_flush & ~mem_stall;

    // Pipeline control outputs, highest-priority condition first.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = ~id_valid;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_bubble = 1'b0;
        end else if (halted_r) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_flush) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b0;
            idex_en     = 1'b1;
            idex_bubble = ~id_valid;
        end
    end

    // Scoreboard advance, HALT latch and stall counter; everything holds while memory is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_valid_r  <= 1'b0;
            dx_rw_r     <= 1'b0;
            dx_mr_r     <= 1'b0;
            dx_dest_r   <= 3'd0;
            xm_valid_r  <= 1'b0;
            xm_rw_r     <= 1'b0;
            xm_mr_r     <= 1'b0;
            xm_dest_r   <= 3'd0;
            mw_valid_r  <= 1'b0;
            mw_rw_r     <= 1'b0;
            mw_mr_r     <= 1'b0;
            mw_dest_r   <= 3'd0;
            halted_r    <= 1'b0;
            stall_cnt_r <= 16'd0;
        end else if (!mem_stall) begin
            mw_valid_r  <= xm_valid_r;
            mw_rw_r     <= xm_rw_r;
            mw_mr_r     <= xm_mr_r;
            mw_dest_r   <= xm_dest_r;
            xm_valid_r  <= dx_valid_r;
            xm_rw_r     <= dx_rw_r;
            xm_mr_r     <= dx_mr_r;
            xm_dest_r   <= dx_dest_r;
            // A non-issuing cycle leaves an empty slot behind (the bubble).
            dx_valid_r  <= issue_s;
            dx_rw_r     <= issue_s & id_regWrite;
            dx_mr_r     <= issue_s & id_memRead;
            dx_dest_r   <= issue_s ? id_writeRegSel : 3'd0;
            if (issue_s && id_HALT) begin
                halted_r <= 1'b1;
            end
            if (count_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign halted       = halted_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven vectors with an expected-result
// queue, plus hand-written async-reset and R0 sequences. Expectations adapt to
// FORWARDING_EN.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  readSel1, readSel2;
    logic        read1Used, read2Used;
    logic        id_regWrite;
    logic [2:0]  id_writeRegSel;
    logic        id_memRead, id_HALT, ex_flush, mem_stall;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted;
    logic [15:0] stall_cycles;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted}
    localparam logic [5:0] C_NORM  = 6'b110100;
    localparam logic [5:0] C_IDLE  = 6'b110110;
    localparam logic [5:0] C_STALL = 6'b000110;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_HALT  = 6'b000111;
    localparam logic [5:0] C_HFRZ  = 6'b000001;
    localparam logic [5:0] C_RST   = 6'b001110;

    typedef struct {
        logic        vld;
        logic [2:0]  rs1, rs2;
        logic        u1, u2, rw;
        logic [2:0]  wsel;
        logic        mr, hlt, fl, ms;
        logic [5:0]  ctl;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t expq[$];
    int   checks = 0;
    int   passed = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .readSel1(readSel1), .readSel2(readSel2),
        .read1Used(read1Used), .read2Used(read2Used),
        .id_regWrite(id_regWrite), .id_writeRegSel(id_writeRegSel),
        .id_memRead(id_memRead), .id_HALT(id_HALT),
        .ex_flush(ex_flush), .mem_stall(mem_stall),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic add(input logic vld, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic u1, input logic u2, input logic rw, input logic [2:0] wsel,
                       input logic mr, input logic hlt, input logic fl, input logic ms,
                       input logic [5:0] ctl, input logic [15:0] cnt);
        vec_t v;
        v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rw = rw;
        v.wsel = wsel; v.mr = mr; v.hlt = hlt; v.fl = fl; v.ms = ms;
        v.ctl = ctl; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic compare(input string name);
        exp_t        e;
        logic [5:0]  act;
        act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted};
        checks++;
        if (expq.size() == 0) begin
            $display("FAIL %s: no expected entry queued, got ctl=%b cnt=%0d", name, act, stall_cycles);
        end else begin
            e = expq.pop_front();
            if (act === e.ctl && stall_cycles === e.cnt) begin
                passed++;
            end else begin
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                         name, act, stall_cycles, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic expect_now(input string name, input logic [5:0] ctl, input logic [15:0] cnt);
        exp_t e;
        e.ctl = ctl; e.cnt = cnt;
        expq.push_back(e);
        compare(name);
    endtask

    task automatic run(input vec_t v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid = v.vld; readSel1 = v.rs1; readSel2 = v.rs2;
        read1Used = v.u1; read2Used = v.u2; id_regWrite = v.rw;
        id_writeRegSel = v.wsel; id_memRead = v.mr; id_HALT = v.hlt;
        ex_flush = v.fl; mem_stall = v.ms;
        e.ctl = v.ctl; e.cnt = v.cnt;
        expq.push_back(e);
        @(negedge clk);
        compare(name);
    endtask

    initial begin
        int s;
        vec_t h;
        rst = 1'b1;
        id_valid = 1'b0; readSel1 = 3'd0; readSel2 = 3'd0; read1Used = 1'b0; read2Used = 1'b0;
        id_regWrite = 1'b0; id_writeRegSel = 3'd0; id_memRead = 1'b0; id_HALT = 1'b0;
        ex_flush = 1'b0; mem_stall = 1'b0;
        #12;
        expect_now("reset_state", C_RST, 16'd0);
        rst = 1'b0;

`ifdef FORWARDING_EN
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0); // ADD R1
        add(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0); // ADD R2,R1 no stall
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0); // LD R3
        add(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 16'd0); // load-use
        add(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd1);
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 16'd1); // LD R5
        for (int i = 0; i < 4; i++)
            add(1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, C_FRZ, 16'd1);
        add(1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 16'd1);
        add(1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd2);
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 16'd2); // LD R3
        s = 2;
`else
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0); // ADD R1
        for (int i = 0; i < 3; i++)
            add(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 16'(i));
        add(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd3);
        add(1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 16'd3);
        for (int i = 0; i < 4; i++)
            add(1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_FRZ, 16'd4);
        add(1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 16'd4);
        add(1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 16'd5);
        add(1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd6); // R3 in DX
        s = 6;
`endif
        // Flush a dependent instruction (also flagged HALT): neither issues nor counts.
        add(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, C_FLUSH, 16'(s));
        add(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE, 16'(s));
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NORM, 16'(s)); // HALT
        add(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_HALT, 16'(s));
        add(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HALT, 16'(s));
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_HFRZ, 16'(s));
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, C_HALT, 16'(s));
        add(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, C_HALT, 16'(s));

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset while halted, between clock edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 expect_now("async_rst_halted", C_RST, 16'd0);
        #1 rst = 1'b0;

        // R0 is tracked: LD R0 then a reader of R0 stalls.
        h.vld = 1'b1; h.rs1 = 3'd0; h.rs2 = 3'd0; h.u1 = 1'b0; h.u2 = 1'b0; h.rw = 1'b1;
        h.wsel = 3'd0; h.mr = 1'b1; h.hlt = 1'b0; h.fl = 1'b0; h.ms = 1'b0;
        h.ctl = C_NORM; h.cnt = 16'd0;
        run(h, "ld_r0");
        h.u1 = 1'b1; h.mr = 1'b0; h.rw = 1'b0; h.ctl = C_STALL; h.cnt = 16'd0;
        run(h, "r0_use_stall");
`ifdef FORWARDING_EN
        h.ctl = C_NORM; h.cnt = 16'd1;
`else
        h.ctl = C_STALL; h.cnt = 16'd1;
`endif
        run(h, "r0_use_second");

        // Asynchronous reset in the middle of the stall clears counter and scoreboard.
        #2 rst = 1'b1;
        #1 expect_now("async_rst_midstall", C_RST, 16'd0);
        #1 rst = 1'b0;
        h.ctl = C_NORM; h.cnt = 16'd0;
        run(h, "post_rst_no_hazard");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard and flow-control unit for the 5-stage pipeline.
- Owns the enables and squash controls for the PC, IF/ID and ID/EX registers. Decode fills ID/EX; this block decides whether, and with what, it is filled.
- Keeps a shadow scoreboard of in-flight destination registers in the DX, XM and MW slots, and stalls decode on RAW hazards.
- Sequences branch/jump flushes, data-memory freezes and HALT drain.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- readSel1, readSel2  in  3 each  source registers of the instruction in IF/ID.
- read1Used, read2Used  in  1 each  the corresponding source is actually read.
- id_regWrite  in  1  decoded instruction writes a register.
- id_writeRegSel  in  3  its destination register (R7 for jump-and-link).
- id_memRead  in  1  decoded instruction is a load.
- id_HALT  in  1  decoded instruction is HALT.
- ex_flush  in  1  branch/jump in EX resolved as redirect this cycle.
- mem_stall  in  1  data memory busy; whole pipeline freezes.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_en  out  1  ID/EX enable.
- idex_bubble  out  1  force the ID/EX control fields HALT, memRead, memWrite and regWrite to 0.
- halted  out  1  HALT has issued; front end is frozen.
- stall_cycles  out  16  saturating count of hazard-stall cycles.

## Operation
- Scoreboard: three slots, DX, XM and MW. Each slot holds {valid, regWrite, dest[2:0], memRead}.
- Scoreboard advance: happens on every clock edge with mem_stall=0.
  - MW<=XM, then XM<=DX.
  - DX<=decoded instruction when it issues. Otherwise DX<=empty.
- An instruction issues when id_valid=1, halted=0, and there is no hazard, ex_flush or mem_stall.
- A source matches a slot when: the source is used, the slot is valid, the slot has regWrite=1, and dest equals the source select.
- Hazard rule with FORWARDING_EN defined: a source matches DX and DX.memRead=1 (load-use).
- Hazard rule without FORWARDING_EN: a source matches any of DX, XM or MW. The register file is not write-through.
- Output priority, highest first:
  - rst: pc_en=0, ifid_en=0, ifid_flush=1, idex_en=1, idex_bubble=1.
  - mem_stall: pc_en=0, ifid_en=0, idex_en=0, ifid_flush=0, idex_bubble=0. Scoreboard, halted and counter hold.
  - halted: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1.
  - ex_flush: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_bubble=1. The instruction in IF/ID does not issue; this applies even if it is a hazard or a HALT.
  - hazard: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1. stall_cycles increments, saturating at 16'hFFFF.
  - normal: pc_en=1, ifid_en=1, idex_en=1, ifid_flush=0. idex_bubble=~id_valid.
- halted: set at the edge where an instruction with id_HALT=1 issues. Clears only on rst.

## Timing
- All outputs are combinational from the current scoreboard, halted and inputs; there is no added latency.
- Scoreboard, halted and stall_cycles update on the rising clk edge.
- rst is asynchronous: it clears all slots, halted and stall_cycles immediately, mid-operation included.
- Load-use with forwarding: exactly 1 stall cycle. The load moves to XM, and the dependent instruction issues the next cycle.
- Without forwarding, stall length:
  - producer in DX: 3 cycles;
  - producer in XM: 2 cycles;
  - producer in MW: 1 cycle.
- mem_stall during a hazard: the stall is extended, but stall_cycles does not count the frozen cycles.
- ex_flush and hazard in the same cycle: the flush wins; the counter does not increment.
- Reads of R0 are tracked like any other register; there is no hardwired-zero exemption.

## Configuration
- FORWARDING_EN defined: an EX/MEM/WB forwarding network exists. Only load-use hazards stall, for 1 cycle.
- FORWARDING_EN undefined: all RAW hazards against DX, XM or MW stall until the producer has left MW.

## Test plan
- Back-to-back dependency (ADD R1,... then ADD R2,R1,...):
  - with FORWARDING_EN: 0 stalls;
  - without: 3 cycles with pc_en=0 and idex_bubble=1, then the instruction issues and stall_cycles=3.
- Load-use (LD R3 then ADD using R3) with FORWARDING_EN: exactly 1 bubble; stall_cycles=1.
- Hazard stall with mem_stall=1 asserted for 4 cycles mid-stall: all enables are 0 for those 4 cycles, and the stall resumes with its remaining count afterwards.
- ex_flush=1 while IF/ID holds a dependent instruction: ifid_flush=1 and idex_bubble=1; no issue and no count.
- HALT issues: halted=1 from the next cycle; pc_en stays 0 and bubbles are issued indefinitely until rst.
- Assert rst asynchronously mid-stall: halted=0, stall_cycles=0 and the scoreboard clears before the next edge.
